// File: rtl/mem_wb_forward_source.sv
// EX/MEM and MEM/WB pipeline registers with data-memory drive, EX-stage
// forwarding selects, load-use stall detection and a saturating stall counter.
module mem_wb_forward_source #(
  parameter int NBits   = 32,
  parameter int CntBits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EX_Valid,
  input  logic [NBits-1:0]   EX_ALUResult,
  input  logic [NBits-1:0]   EX_WriteData,
  input  logic [NBits-1:0]   EX_PC_4,
  input  logic [4:0]         EX_WriteRegister,
  input  logic               EX_RegWrite,
  input  logic               EX_MemRead,
  input  logic               EX_MemWrite,
  input  logic               EX_MemtoReg,
  input  logic               EX_Link,
  input  logic [4:0]         EX_Rs,
  input  logic [4:0]         EX_Rt,
  input  logic [4:0]         ID_Rs,
  input  logic [4:0]         ID_Rt,
  input  logic [NBits-1:0]   MemReadData,
  output logic [NBits-1:0]   MemAddress,
  output logic [NBits-1:0]   MemWriteData,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [NBits-1:0]   MEM_ALUResult,
  output logic [NBits-1:0]   ALUMemOrPCData,
  output logic               WB_RegWrite,
  output logic [4:0]         WB_WriteRegister,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB,
  output logic               Stall,
  output logic               LoadUseViolation,
  output logic [CntBits-1:0] StallCount
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             memto_reg;
    logic             link;
    logic [4:0]       wr;
    logic [NBits-1:0] alu;
    logic [NBits-1:0] wdata;
    logic [NBits-1:0] pc4;
  } exmem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             memto_reg;
    logic             link;
    logic [4:0]       wr;
    logic [NBits-1:0] alu;
    logic [NBits-1:0] mdata;
    logic [NBits-1:0] pc4;
  } memwb_t;

  exmem_t             exmem_d, exmem_q;
  memwb_t             memwb_d, memwb_q;
  logic [CntBits-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    exmem_d           = '0;
    exmem_d.valid     = EX_Valid;
    exmem_d.reg_write = EX_RegWrite;
    exmem_d.mem_read  = EX_MemRead;
    exmem_d.mem_write = EX_MemWrite;
    exmem_d.memto_reg = EX_MemtoReg;
    exmem_d.link      = EX_Link;
    exmem_d.wr        = EX_WriteRegister;
    exmem_d.alu       = EX_ALUResult;
    exmem_d.wdata     = EX_WriteData;
    exmem_d.pc4       = EX_PC_4;

    memwb_d           = '0;
    memwb_d.valid     = exmem_q.valid;
    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.memto_reg = exmem_q.memto_reg;
    memwb_d.link      = exmem_q.link;
    memwb_d.wr        = exmem_q.wr;
    memwb_d.alu       = exmem_q.alu;
    memwb_d.mdata     = MemReadData;
    memwb_d.pc4       = exmem_q.pc4;

    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != {CntBits{1'b1}}))
      stall_cnt_d = stall_cnt_q + CntBits'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Loads in EX/MEM have no data yet, so they are excluded from the 2'b10 source.
  logic exmem_alu_src, exmem_load, memwb_src;
  assign exmem_alu_src = exmem_q.valid & exmem_q.reg_write & ~exmem_q.memto_reg & (exmem_q.wr != 5'd0);
  assign exmem_load    = exmem_q.valid & exmem_q.reg_write &  exmem_q.memto_reg & (exmem_q.wr != 5'd0);
  assign memwb_src     = memwb_q.valid & memwb_q.reg_write & (memwb_q.wr != 5'd0);

  logic [1:0][4:0] ex_src;
  logic [1:0][1:0] fwd;
  logic [1:0]      lu_hit;
  assign ex_src = {EX_Rt, EX_Rs};

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    logic ex_hit, wb_hit;
    assign ex_hit    = exmem_alu_src & (exmem_q.wr == ex_src[g]);
    assign wb_hit    = memwb_src     & (memwb_q.wr == ex_src[g]);
    assign lu_hit[g] = exmem_load    & (exmem_q.wr == ex_src[g]);
    assign fwd[g]    = ex_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
  end

  assign ForwardA         = fwd[0];
  assign ForwardB         = fwd[1];
  assign LoadUseViolation = |lu_hit;

  assign Stall = EX_Valid & EX_MemRead & EX_RegWrite & (EX_WriteRegister != 5'd0) &
                 ((EX_WriteRegister == ID_Rs) | (EX_WriteRegister == ID_Rt));
  assign StallCount = stall_cnt_q;

  assign MemAddress       = exmem_q.alu;
  assign MemWriteData     = exmem_q.wdata;
  assign MemRead          = exmem_q.valid & exmem_q.mem_read;
  assign MemWrite         = exmem_q.valid & exmem_q.mem_write;
  assign MEM_ALUResult    = exmem_q.alu;
  assign ALUMemOrPCData   = memwb_q.memto_reg ? memwb_q.mdata : (memwb_q.link ? memwb_q.pc4 : memwb_q.alu);
  assign WB_RegWrite      = memwb_q.valid & memwb_q.reg_write;
  assign WB_WriteRegister = memwb_q.wr;

endmodule

// File: tb/tb_mem_wb_forward_source.sv
// Scenario bench for mem_wb_forward_source: forwarding priority, load-use stall,
// load/JAL write-back, reset flush and stall-counter saturation.
module tb_mem_wb_forward_source;
  logic        clk = 1'b0;
  logic        reset;
  logic        EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_Link;
  logic [31:0] EX_ALUResult, EX_WriteData, EX_PC_4, MemReadData;
  logic [4:0]  EX_WriteRegister, EX_Rs, EX_Rt, ID_Rs, ID_Rt;
  logic [31:0] MemAddress, MemWriteData, MEM_ALUResult, ALUMemOrPCData;
  logic        MemRead, MemWrite, WB_RegWrite, Stall, LoadUseViolation;
  logic [4:0]  WB_WriteRegister;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] StallCount;

  mem_wb_forward_source #(.NBits(32), .CntBits(16)) dut (
    .clk(clk), .reset(reset), .EX_Valid(EX_Valid), .EX_ALUResult(EX_ALUResult),
    .EX_WriteData(EX_WriteData), .EX_PC_4(EX_PC_4), .EX_WriteRegister(EX_WriteRegister),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_Link(EX_Link), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .MemReadData(MemReadData), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MEM_ALUResult(MEM_ALUResult), .ALUMemOrPCData(ALUMemOrPCData),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall),
    .LoadUseViolation(LoadUseViolation), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_ex;
    EX_Valid = 0; EX_RegWrite = 0; EX_MemRead = 0; EX_MemWrite = 0; EX_MemtoReg = 0; EX_Link = 0;
    EX_ALUResult = 0; EX_WriteData = 0; EX_PC_4 = 0; EX_WriteRegister = 0;
    EX_Rs = 0; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0; MemReadData = 0;
  endtask

  task automatic drive_alu(input logic [4:0] wr, input logic [31:0] alu);
    clear_ex;
    EX_Valid = 1; EX_RegWrite = 1; EX_WriteRegister = wr; EX_ALUResult = alu;
  endtask

  task automatic drive_lw(input logic [4:0] wr, input logic [31:0] addr);
    clear_ex;
    EX_Valid = 1; EX_RegWrite = 1; EX_MemRead = 1; EX_MemtoReg = 1;
    EX_WriteRegister = wr; EX_ALUResult = addr;
  endtask

  task automatic test_reset;
    clear_ex; reset = 1; tick; tick; reset = 0; #1;
    vectors++;
    if ({ForwardA, ForwardB, Stall, LoadUseViolation, MemRead, MemWrite, WB_RegWrite} !== 9'd0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 0",
        {ForwardA, ForwardB, Stall, LoadUseViolation, MemRead, MemWrite, WB_RegWrite});
    end
    vectors++;
    if (StallCount !== 16'd0) begin
      miscompares++; $display("FAIL reset_cnt: got %h expected 0000", StallCount);
    end
    vectors++;
    if ({MemAddress, ALUMemOrPCData, WB_WriteRegister} !== 69'd0) begin
      miscompares++; $display("FAIL reset_data: got %h/%h/%0d expected 0", MemAddress, ALUMemOrPCData, WB_WriteRegister);
    end
  endtask

  task automatic test_stall;
    drive_lw(4, 32'h0); ID_Rt = 4; sb_q.push_back(32'd1); #1;
    vectors++;
    if (Stall !== 1'b1) begin miscompares++; $display("FAIL stall_lw: got %b expected 1", Stall); end
    tick;
    EX_Valid = 0; #1;
    vectors++;
    if (Stall !== 1'b0) begin miscompares++; $display("FAIL stall_bubble: got %b expected 0", Stall); end
    exp_v = sb_q.pop_front();
    vectors++;
    if (StallCount !== exp_v[15:0]) begin
      miscompares++; $display("FAIL stall_cnt1: got %h expected %h", StallCount, exp_v[15:0]);
    end
    drive_lw(0, 32'h0); ID_Rt = 0; ID_Rs = 0; #1;
    vectors++;
    if (Stall !== 1'b0) begin miscompares++; $display("FAIL stall_r0: got %b expected 0", Stall); end
    tick;
    vectors++;
    if (StallCount !== 16'd1) begin miscompares++; $display("FAIL stall_cnt_r0: got %h expected 0001", StallCount); end
  endtask

  task automatic test_fwd_exmem;
    drive_alu(3, 32'h0000_0005); sb_q.push_back(32'h0000_0005); tick;
    clear_ex; EX_Valid = 1; EX_Rs = 3; #1;
    vectors++;
    if (ForwardA !== 2'b10) begin miscompares++; $display("FAIL fwdA_exmem: got %b expected 10", ForwardA); end
    vectors++;
    if (ForwardB !== 2'b00) begin miscompares++; $display("FAIL fwdB_nomatch: got %b expected 00", ForwardB); end
    exp_v = sb_q.pop_front();
    vectors++;
    if (MEM_ALUResult !== exp_v) begin miscompares++; $display("FAIL mem_alu: got %h expected %h", MEM_ALUResult, exp_v); end
  endtask

  task automatic test_fwd_priority;
    drive_alu(3, 32'h9); tick;
    drive_alu(3, 32'h5); tick;
    clear_ex; EX_Valid = 1; EX_Rt = 3; #1;
    vectors++;
    if (ForwardB !== 2'b10) begin miscompares++; $display("FAIL fwdB_prio: got %b expected 10", ForwardB); end
    drive_alu(3, 32'h9); sb_q.push_back(32'h9); tick;
    drive_alu(5, 32'h5); tick;
    clear_ex; EX_Valid = 1; EX_Rt = 3; #1;
    vectors++;
    if (ForwardB !== 2'b01) begin miscompares++; $display("FAIL fwdB_memwb: got %b expected 01", ForwardB); end
    exp_v = sb_q.pop_front();
    vectors++;
    if (ALUMemOrPCData !== exp_v) begin miscompares++; $display("FAIL wb_data: got %h expected %h", ALUMemOrPCData, exp_v); end
    drive_alu(0, 32'h7); tick;
    drive_alu(0, 32'h8); tick;
    clear_ex; EX_Valid = 1; #1;
    vectors++;
    if ({ForwardA, ForwardB} !== 4'b0000) begin
      miscompares++; $display("FAIL fwd_r0: got %b%b expected 0000", ForwardA, ForwardB);
    end
  endtask

  task automatic test_load_forward;
    clear_ex; tick; tick;
    drive_lw(4, 32'h100); sb_q.push_back(32'hDEAD_BEEF); tick;
    clear_ex; MemReadData = 32'hDEAD_BEEF; EX_Rs = 4; #1;
    vectors++;
    if ({MemRead, MemAddress} !== {1'b1, 32'h100}) begin
      miscompares++; $display("FAIL lw_mem: got %b/%h expected 1/00000100", MemRead, MemAddress);
    end
    vectors++;
    if ({LoadUseViolation, ForwardA} !== 3'b100) begin
      miscompares++; $display("FAIL lu_violation: got %b/%b expected 1/00", LoadUseViolation, ForwardA);
    end
    EX_Rs = 0; tick;
    clear_ex; EX_Valid = 1; EX_Rs = 4; #1;
    vectors++;
    if ({LoadUseViolation, ForwardA} !== 3'b001) begin
      miscompares++; $display("FAIL lw_fwdA: got %b/%b expected 0/01", LoadUseViolation, ForwardA);
    end
    exp_v = sb_q.pop_front();
    vectors++;
    if (ALUMemOrPCData !== exp_v) begin miscompares++; $display("FAIL lw_data: got %h expected %h", ALUMemOrPCData, exp_v); end
  endtask

  task automatic test_jal;
    clear_ex; tick; tick;
    EX_Valid = 1; EX_RegWrite = 1; EX_Link = 1; EX_WriteRegister = 31;
    EX_PC_4 = 32'h0040_0008; EX_ALUResult = 32'h0000_1234;
    sb_q.push_back(32'h0040_0008); tick;
    clear_ex; #1;
    vectors++;
    if (WB_RegWrite !== 1'b0) begin miscompares++; $display("FAIL jal_early: got %b expected 0", WB_RegWrite); end
    tick;
    vectors++;
    if ({WB_RegWrite, WB_WriteRegister} !== {1'b1, 5'd31}) begin
      miscompares++; $display("FAIL jal_wb: got %b/%0d expected 1/31", WB_RegWrite, WB_WriteRegister);
    end
    exp_v = sb_q.pop_front();
    vectors++;
    if (ALUMemOrPCData !== exp_v) begin miscompares++; $display("FAIL jal_data: got %h expected %h", ALUMemOrPCData, exp_v); end
  endtask

  task automatic test_reset_mid;
    drive_alu(7, 32'h11); tick;
    clear_ex; EX_Valid = 1; EX_MemWrite = 1; EX_ALUResult = 32'h40; EX_WriteData = 32'h77; tick;
    drive_alu(8, 32'h22); #1;
    vectors++;
    if ({MemWrite, MemWriteData, WB_RegWrite} !== {1'b1, 32'h77, 1'b1}) begin
      miscompares++; $display("FAIL sw_inflight: got %b/%h/%b expected 1/00000077/1", MemWrite, MemWriteData, WB_RegWrite);
    end
    reset = 1; tick; reset = 0; clear_ex; #1;
    vectors++;
    if ({MemWrite, MemRead, WB_RegWrite, MemAddress} !== 35'd0) begin
      miscompares++; $display("FAIL reset_flush: got %b/%b/%b/%h expected 0/0/0/0", MemWrite, MemRead, WB_RegWrite, MemAddress);
    end
    tick;
    vectors++;
    if (WB_RegWrite !== 1'b0) begin miscompares++; $display("FAIL reset_flush_wb: got %b expected 0", WB_RegWrite); end
  endtask

  task automatic test_saturate;
    vectors++;
    if (StallCount !== 16'd0) begin miscompares++; $display("FAIL sat_start: got %h expected 0000", StallCount); end
    drive_lw(4, 32'h0); ID_Rt = 4;
    repeat (16'hFFFF) tick;
    vectors++;
    if (StallCount !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h expected ffff", StallCount); end
    repeat (4) tick;
    vectors++;
    if (StallCount !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h expected ffff", StallCount); end
    reset = 1; tick; reset = 0; clear_ex; #1;
    vectors++;
    if (StallCount !== 16'd0) begin miscompares++; $display("FAIL reset_wins: got %h expected 0000", StallCount); end
  endtask

  initial begin
    reset = 1; clear_ex;
    test_reset;
    test_stall;
    test_fwd_exmem;
    test_fwd_priority;
    test_load_forward;
    test_jal;
    test_reset_mid;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
